sl_transmitter: RTL and testbench

Serial-line (SL) transmitter: the driving end of the two-wire SL link that `SL_transiever` receives. It takes a parallel word of 8–32 bits with a start strobe and serialises it onto `sl0`/`sl1`. Framing is LSB first, then one odd-parity bit, then one stop symbol. The block sits beside the receiver, sharing its clock, so the link can be driven from on-chip logic and looped back for self-test.

---
 rtl/sl_pkg.sv | 22 ++
 rtl/sl_transmitter.sv | 146 ++++++++++++++
 tb/tb_sl_transmitter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sl_pkg.sv
// Shared types and constants for the SL serial link.
// Used by both the transmitter and the receiver.
package sl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } sl_state_t;

  typedef enum logic [1:0] {
    DATA,
    PARITY,
    STOP
  } sl_sym_t;

  localparam int SL_MIN_LEN   = 8;
  localparam int SL_MAX_LEN   = 32;
  localparam int SL_PULSE_LEN = 16;
  localparam int SL_GAP_LEN   = 16;

endpackage

// File: rtl/sl_transmitter.sv
// SL link transmitter: serialises a 8..32 bit word LSB first,
// then odd parity, then a stop symbol, on the sl0/sl1 lines.
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int PULSE_LEN = SL_PULSE_LEN,
  parameter int GAP_LEN   = SL_GAP_LEN,
  parameter int MAX_LEN   = SL_MAX_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic [5:0]  word_len,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        len_err,
  output logic        sl0,
  output logic        sl1
);

  localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] P_END = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] G_END = TW'(GAP_LEN - 1);

  sl_state_t   state, state_n;
  sl_sym_t     sym, sym_n;
  logic [TW-1:0] timer, timer_n;
  logic [5:0]  bit_cnt, bit_n;
  logic [5:0]  len_q, len_n;
  logic [31:0] shreg, shreg_n;
  logic        par, par_n;
  logic        busy_n, done_n, len_err_n;
  logic        sl0_n, sl1_n;
  logic        len_ok, bit_v;
  logic [31:0] mask;

  assign len_ok = (word_len >= 6'(SL_MIN_LEN)) &&
                  ({26'd0, word_len} <= 32'(MAX_LEN));
  // A shift of 32 yields zero, so a full-width word masks to all ones.
  assign mask = ~(32'hFFFF_FFFF << word_len);

  always_comb begin
    state_n   = state;
    sym_n     = sym;
    timer_n   = timer;
    bit_n     = bit_cnt;
    len_n     = len_q;
    shreg_n   = shreg;
    par_n     = par;
    done_n    = 1'b0;
    len_err_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_n = PULSE;
            sym_n   = DATA;
            timer_n = '0;
            bit_n   = '0;
            len_n   = word_len;
            shreg_n = data_in;
            par_n   = ~^(data_in & mask);
          end else begin
            len_err_n = 1'b1;
          end
        end
      end
      PULSE: begin
        if (timer == P_END) begin
          state_n = GAP;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      GAP: begin
        if (timer == G_END) begin
          state_n = PULSE;
          timer_n = '0;
          unique case (sym)
            DATA: begin
              if (bit_cnt < len_q - 6'd1) begin
                bit_n   = bit_cnt + 6'd1;
                shreg_n = shreg >> 1;
              end else begin
                sym_n = PARITY;
              end
            end
            PARITY: sym_n = STOP;
            STOP: begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Lines are registered from the next state so they track it exactly.
    bit_v = (sym_n == PARITY) ? par_n : shreg_n[0];
    sl0_n = 1'b1;
    sl1_n = 1'b1;
    if (state_n == PULSE) begin
      sl0_n = (sym_n != STOP) && bit_v;
      sl1_n = (sym_n != STOP) && !bit_v;
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sym     <= DATA;
      timer   <= '0;
      bit_cnt <= '0;
      len_q   <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      len_err <= 1'b0;
      sl0     <= 1'b1;
      sl1     <= 1'b1;
    end else begin
      state   <= state_n;
      sym     <= sym_n;
      timer   <= timer_n;
      bit_cnt <= bit_n;
      len_q   <= len_n;
      shreg   <= shreg_n;
      par     <= par_n;
      busy    <= busy_n;
      done    <= done_n;
      len_err <= len_err_n;
      sl0     <= sl0_n;
      sl1     <= sl1_n;
    end
  end

endmodule

// File: tb/tb_sl_transmitter.sv
// Randomised bench for sl_transmitter against a per-cycle line model.
// Status vector compared each cycle is {busy,len_err,done,sl0,sl1}.
module tb_sl_transmitter;

  localparam int P   = 16;
  localparam int G   = 16;
  localparam int SYM = P + G;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [5:0]  word_len;
  logic        start;
  logic        busy, done, len_err, sl0, sl1;

  int total = 0;
  int bad   = 0;

  sl_transmitter dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .word_len(word_len), .start(start), .busy(busy),
    .done(done), .len_err(len_err), .sl0(sl0), .sl1(sl1)
  );

  always #5 clk = ~clk;

  // Expected {sl0,sl1} k cycles after the first low cycle of a word.
  function automatic logic [1:0] exp_lines(
    input logic [31:0] d, input int len, input int k);
    int s, ph, ones;
    logic v;
    s  = k / SYM;
    ph = k % SYM;
    if (ph >= P) return 2'b11;
    if (s < len) begin
      v = d[s];
    end else if (s == len) begin
      ones = 0;
      for (int i = 0; i < len; i++) ones += int'(d[i]);
      v = (ones % 2 == 0);
    end else begin
      return 2'b00;
    end
    return v ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [4:0] status();
    return {busy, len_err, done, sl0, sl1};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data_in = '0; word_len = 6'd8;
    repeat (3) @(negedge clk);
    total++;
    if (status() !== 5'b00011) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", status(), 5'b00011);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Sends one word; optionally pulses a stray start at cycle inject.
  task automatic test_word(input logic [31:0] d, input int len,
                           input int inject);
    int n;
    logic [4:0] exp;
    n = (len + 2) * SYM;
    data_in = d; word_len = 6'(len); start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp = {3'b100, exp_lines(d, len, k)};
      total++;
      if (status() !== exp) begin
        bad++;
        $display("FAIL word len=%0d d=%h k=%0d got=%b want=%b",
                 len, d, k, status(), exp);
      end
      data_in  = $urandom;
      word_len = 6'($urandom);
      if (k == inject) start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (status() !== 5'b00111) begin
      bad++;
      $display("FAIL done_cycle len=%0d got=%b want=%b",
               len, status(), 5'b00111);
    end
    @(negedge clk);
    total++;
    if (status() !== 5'b00011) begin
      bad++;
      $display("FAIL after_done len=%0d got=%b want=%b",
               len, status(), 5'b00011);
    end
  endtask

  task automatic test_known_words();
    test_word(32'h0000_E3F1, 16, -1);
    test_word(32'hFFFF_FF01, 8, -1);
    test_word(32'hFFFF_FFFF, 32, -1);
  endtask

  task automatic test_random_words();
    for (int i = 0; i < 6; i++)
      test_word($urandom, int'($urandom_range(8, 32)), -1);
  endtask

  task automatic test_busy_ignore();
    test_word($urandom, 12, 100);
    test_word($urandom, 9, 40);
  endtask

  task automatic test_len_err();
    int lens[6];
    lens = '{7, 33, 0, 63, 1, 40};
    lens[4] = int'($urandom_range(1, 7));
    lens[5] = int'($urandom_range(33, 63));
    foreach (lens[i]) begin
      @(negedge clk);
      data_in = $urandom; word_len = 6'(lens[i]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (status() !== 5'b01011) begin
        bad++;
        $display("FAIL len_err_pulse len=%0d got=%b want=%b",
                 lens[i], status(), 5'b01011);
      end
      @(negedge clk);
      total++;
      if (status() !== 5'b00011) begin
        bad++;
        $display("FAIL len_err_clear len=%0d got=%b want=%b",
                 lens[i], status(), 5'b00011);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[4];
    logic [4:0] exp;
    int dones;
    dones = 0;
    foreach (w[i]) w[i] = $urandom;
    @(negedge clk);
    data_in = w[0]; word_len = 6'd8; start = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 10 * SYM; k++) begin
        @(negedge clk);
        exp = {3'b100, exp_lines(w[j], 8, k)};
        total++;
        if (status() !== exp) begin
          bad++;
          $display("FAIL b2b word=%0d k=%0d got=%b want=%b",
                   j, k, status(), exp);
        end
        data_in  = $urandom;
        word_len = 6'($urandom);
      end
      @(negedge clk);
      if (done === 1'b1) dones++;
      total++;
      if (status() !== 5'b00111) begin
        bad++;
        $display("FAIL b2b_gap word=%0d got=%b want=%b",
                 j, status(), 5'b00111);
      end
      word_len = 6'd8;
      if (j < 3) data_in = w[j+1];
      else start = 1'b0;
    end
    @(negedge clk);
    total++;
    if (dones !== 4 || status() !== 5'b00011) begin
      bad++;
      $display("FAIL b2b_end dones=%0d got=%b want=4 %b",
               dones, status(), 5'b00011);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [4:0] exp;
    d = $urandom;
    @(negedge clk);
    data_in = d; word_len = 6'd16; start = 1'b1;
    for (int k = 0; k < 136; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp = {3'b100, exp_lines(d, 16, k)};
      total++;
      if (status() !== exp) begin
        bad++;
        $display("FAIL pre_reset k=%0d got=%b want=%b",
                 k, status(), exp);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (status() !== 5'b00011) begin
      bad++;
      $display("FAIL mid_reset got=%b want=%b", status(), 5'b00011);
    end
    for (int k = 0; k < 2 * SYM; k++) begin
      @(negedge clk);
      total++;
      if (status() !== 5'b00011) begin
        bad++;
        $display("FAIL no_resume k=%0d got=%b want=%b",
                 k, status(), 5'b00011);
      end
    end
    test_word($urandom, 16, -1);
  endtask

  initial begin
    test_reset();
    test_known_words();
    test_len_err();
    test_random_words();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
